fifo_write_arbiter: RTL

- Shares the write port of one single-clock FIFO between NUM_PORTS producers using round-robin arbitration.
- The winning requester holds a burst grant for up to MAX_BURST words, then the grant rotates.
- Applies FIFO backpressure (fifoFull) so that no write is ever presented to a full FIFO and no data is dropped.
- Sits directly in front of the FIFO's writeEnable/writeData/full pins.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_write_arbiter_if.sv | 29 ++
 rtl/rr_picker.sv | 38 +++
 rtl/fifo_write_arbiter.sv | 96 +++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO-side definitions: width helpers and the write-arbiter state encoding.
package fifo_pkg;

   localparam logic IDLE  = 1'b0;
   localparam logic GRANT = 1'b1;

   // Width of an index over n items; kept at one bit minimum so a port index always exists.
   function automatic int indexBits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int countBits(input int maxCount);
      return $clog2(maxCount + 1);
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer-side request bus plus the FIFO write pins, shared by the arbiter and its environment.
interface fifo_write_arbiter_if
   import fifo_pkg::*;
#(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 8
);
   localparam int PORT_BITS = indexBits(NUM_PORTS);

   logic [NUM_PORTS-1:0]            reqValid;
   logic [NUM_PORTS*DATA_WIDTH-1:0] reqData;
   logic [NUM_PORTS-1:0]            reqReady;
   logic                            fifoWriteEnable;
   logic [DATA_WIDTH-1:0]           fifoWriteData;
   logic                            fifoFull;
   logic                            grantValid;
   logic [PORT_BITS-1:0]            grantIndex;

   modport master (
      input  reqValid, reqData, fifoFull,
      output reqReady, fifoWriteEnable, fifoWriteData, grantValid, grantIndex
   );

   modport slave (
      output reqValid, reqData, fifoFull,
      input  reqReady, fifoWriteEnable, fifoWriteData, grantValid, grantIndex
   );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester after lastOwner, wrapping modulo NUM_PORTS.
module rr_picker
   import fifo_pkg::*;
#(
   parameter  int NUM_PORTS = 4,
   localparam int PORT_BITS = indexBits(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] request,
   input  logic [PORT_BITS-1:0] lastOwner,
   output logic                 anyRequest,
   output logic [PORT_BITS-1:0] pickIndex
);

   logic [NUM_PORTS-1:0] rotated;
   int                   offset;

   // Rotate so lastOwner+1 sits at bit 0, take the lowest set bit, then map back to a port number.
   always_comb begin
      rotated = '0;
      offset  = 0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         for (int j = 0; j < NUM_PORTS; j++) begin
            if (((int'(lastOwner) + 1 + k) % NUM_PORTS) == j) begin
               rotated[k] = request[j];
            end
         end
      end
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (rotated[k]) begin
            offset = k;
         end
      end
      pickIndex = PORT_BITS'((int'(lastOwner) + 1 + offset) % NUM_PORTS);
   end

   assign anyRequest = |request;

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_PORTS producers,
// with backpressure from the FIFO full flag.
module fifo_write_arbiter
   import fifo_pkg::*;
#(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input logic                  clock,
   input logic                  asyncReset,
   fifo_write_arbiter_if.master bus
);

   localparam int PORT_BITS  = indexBits(NUM_PORTS);
   localparam int BURST_BITS = countBits(MAX_BURST);

   logic                  state;
   logic [PORT_BITS-1:0]  owner;
   logic [PORT_BITS-1:0]  lastOwner;
   logic [BURST_BITS-1:0] burstCount;

   logic                  anyRequest;
   logic [PORT_BITS-1:0]  pickIndex;
   logic                  granted;
   logic                  ownerValid;
   logic [DATA_WIDTH-1:0] ownerData;
   logic [NUM_PORTS-1:0]  readyVec;
   logic                  transfer;
   logic                  burstDone;

   rr_picker #(.NUM_PORTS(NUM_PORTS)) picker (
      .request    (bus.reqValid),
      .lastOwner  (lastOwner),
      .anyRequest (anyRequest),
      .pickIndex  (pickIndex)
   );

   assign granted = (state == GRANT);

   // Only the owner's valid and data are ever looked at, so non-owner data cannot leak through.
   always_comb begin
      ownerValid = 1'b0;
      ownerData  = '0;
      readyVec   = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (owner == PORT_BITS'(i)) begin
            ownerValid  = bus.reqValid[i];
            ownerData   = bus.reqData[i*DATA_WIDTH +: DATA_WIDTH];
            readyVec[i] = granted && !bus.fifoFull;
         end
      end
   end

   assign transfer            = granted && ownerValid && !bus.fifoFull;
   assign burstDone           = (burstCount == BURST_BITS'(MAX_BURST - 1));
   assign bus.reqReady        = readyVec;
   assign bus.fifoWriteEnable = transfer;
   assign bus.fifoWriteData   = granted ? ownerData : '0;
   assign bus.grantValid      = granted;
   assign bus.grantIndex      = owner;

   // A full FIFO only stalls the owner; rotation happens on a finished burst or a dropped valid.
   always_ff @(posedge clock or posedge asyncReset) begin
      if (asyncReset) begin
         state      <= IDLE;
         owner      <= '0;
         lastOwner  <= PORT_BITS'(NUM_PORTS - 1);
         burstCount <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (anyRequest) begin
                  owner      <= pickIndex;
                  burstCount <= '0;
                  state      <= GRANT;
               end
            end
            default: begin
               if (transfer && burstDone) begin
                  state      <= IDLE;
                  lastOwner  <= owner;
                  burstCount <= '0;
               end else if (transfer) begin
                  burstCount <= burstCount + 1'b1;
               end else if (!ownerValid) begin
                  state      <= IDLE;
                  lastOwner  <= owner;
                  burstCount <= '0;
               end
            end
         endcase
      end
   end

endmodule
